// File: rtl/stopwatch_lap.sv
// Six-digit BCD stopwatch (mm:ss.cc) with prescaler, up/down count, preset load,
// lap freeze and start/stop/clear FSM. Define STOPWATCH_SEG_ACTIVE_LOW_EN for inverted segments.
module stopwatch_lap #(
  parameter int unsigned CLK_FREQ_HZ = 100000000,
  parameter int unsigned TICK_HZ     = 100,
  parameter int unsigned PRE_W       = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_stop,
  input  logic        lap,
  input  logic        clear,
  input  logic        dir,
  input  logic        load,
  input  logic [23:0] load_value,
  output logic [23:0] bcd_out,
  output logic [41:0] seg_out,
  output logic        running,
  output logic        lap_active,
  output logic        expired
);

  localparam int unsigned DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_e;

  state_e           state_q;
  logic [23:0]      cnt_q;
  logic [23:0]      lap_q;
  logic [PRE_W-1:0] pre_q;
  logic             lap_active_q;
  logic             expired_q;

  logic [23:0] cnt_up;
  logic [23:0] cnt_dn;
  logic [23:0] load_clamped;
  logic [3:0]  dig;
  logic [3:0]  ldig;
  logic        carry;
  logic        borrow;
  logic        tick;
  logic        count_en;
  logic        hold_state;
  logic [41:0] seg_raw;

  function automatic logic [3:0] digit_max(input int unsigned idx);
    return (idx == 3 || idx == 5) ? 4'd5 : 4'd9;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Single-cycle carry/borrow ripple across all six fields, plus preset clamping.
  always_comb begin
    cnt_up       = '0;
    cnt_dn       = '0;
    load_clamped = '0;
    dig          = '0;
    ldig         = '0;
    carry        = 1'b1;
    borrow       = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      dig  = cnt_q[4*i +: 4];
      ldig = load_value[4*i +: 4];
      if (carry) cnt_up[4*i +: 4] = (dig == digit_max(i)) ? 4'd0 : dig + 4'd1;
      else       cnt_up[4*i +: 4] = dig;
      if (borrow) cnt_dn[4*i +: 4] = (dig == 4'd0) ? digit_max(i) : dig - 4'd1;
      else        cnt_dn[4*i +: 4] = dig;
      carry  = carry && (dig == digit_max(i));
      borrow = borrow && (dig == 4'd0);
      load_clamped[4*i +: 4] = (ldig > digit_max(i)) ? digit_max(i) : ldig;
    end
  end

  assign tick       = (pre_q == PRE_MAX);
  assign hold_state = (state_q == IDLE) || (state_q == PAUSE);
  // A load pulse outranks start_stop even though it is ignored in RUN, so counting continues.
  assign count_en   = (state_q == RUN) && (load || !start_stop);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      lap_q        <= '0;
      pre_q        <= '0;
      lap_active_q <= 1'b0;
      expired_q    <= 1'b0;
    end else begin
      expired_q <= 1'b0;
      if (clear) begin
        state_q      <= IDLE;
        cnt_q        <= '0;
        pre_q        <= '0;
        lap_active_q <= 1'b0;
      end else begin
        if (load) begin
          if (hold_state) begin
            cnt_q        <= load_clamped;
            lap_active_q <= 1'b0;
          end
        end else if (start_stop) begin
          case (state_q)
            IDLE, PAUSE: begin
              if (dir && cnt_q == '0) begin
                state_q   <= EXPIRED;
                expired_q <= 1'b1;
              end else begin
                state_q <= RUN;
                pre_q   <= '0;
              end
            end
            RUN:     state_q <= PAUSE;
            default: ;
          endcase
        end else if (lap) begin
          if (state_q == RUN) begin
            if (lap_active_q) begin
              lap_active_q <= 1'b0;
            end else begin
              lap_q        <= cnt_q;
              lap_active_q <= 1'b1;
            end
          end else if (state_q == PAUSE) begin
            lap_active_q <= 1'b0;
          end
        end

        if (count_en) begin
          if (tick) begin
            pre_q <= '0;
            if (dir) begin
              if (cnt_q == 24'h000001) begin
                cnt_q     <= '0;
                state_q   <= EXPIRED;
                expired_q <= 1'b1;
              end else begin
                cnt_q <= cnt_dn;
              end
            end else begin
              cnt_q <= cnt_up;
            end
          end else begin
            pre_q <= pre_q + 1'b1;
          end
        end
      end
    end
  end

  assign bcd_out    = lap_active_q ? lap_q : cnt_q;
  assign running    = (state_q == RUN);
  assign lap_active = lap_active_q;
  assign expired    = expired_q;

  always_comb begin
    seg_raw = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      seg_raw[7*i +: 7] = seg7(bcd_out[4*i +: 4]);
    end
  end

`ifdef STOPWATCH_SEG_ACTIVE_LOW_EN
  assign seg_out = ~seg_raw;
`else
  assign seg_out = seg_raw;
`endif

endmodule
